// File: rtl/miim_phy_model.sv
// miim_phy_model: behavioural clause-22 MDIO management slave (PHY model).
// Samples MDC/MDIO on the bench clock, decodes read/write frames addressed
// to PHY_ADDR, keeps a small register file, and drives read data on MDIO.
//
// Parameters: PHY_ADDR, NUM_REGS (1..32), PHY_ID1/PHY_ID2 (regs 2/3).
// Ports:
//   clk           bench sampling clock (>= 8x MDC)
//   rst           synchronous active-high reset
//   mdc_i         management clock, asynchronous to clk
//   mdio_i        MDIO line as seen by the PHY
//   mdio_o        PHY drive value
//   mdio_oe       PHY output enable (tristate built outside)
//   phy_resetn_i  active-low hardware reset, same effect as rst
//   phy_intn_o    active-low interrupt
//   speed_o       one-hot speed: 100 = 1G, 010 = 100M, 001 = 10M
// Optional feature macro: MIIM_PHY_MODEL_INTR_EN (reg18 int enable,
// reg19 int status, interrupt output). Without it phy_intn_o is tied high.
module miim_phy_model #(
    parameter logic [4:0]  PHY_ADDR = 5'd0,
    parameter int          NUM_REGS = 32,
    parameter logic [15:0] PHY_ID1  = 16'h0141,
    parameter logic [15:0] PHY_ID2  = 16'h0CC2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mdc_i,
    input  logic       mdio_i,
    output logic       mdio_o,
    output logic       mdio_oe,
    input  logic       phy_resetn_i,
    output logic       phy_intn_o,
    output logic [2:0] speed_o
);

    typedef enum logic [3:0] {
        S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_SKIP,
        S_TA_RD, S_TA_WR, S_RDATA, S_WDATA
    } state_t;

    state_t      state, state_nxt;
    logic        irst;
    logic [1:0]  mdc_sync;
    logic        mdc_q;
    logic        rise, fall;
    logic [5:0]  pre_cnt;
    logic [4:0]  cnt;
    logic [14:0] sh;
    logic        op_rd;
    logic [4:0]  phyad_r, regad_r;
    logic [15:0] shadow;
    logic [15:0] regs [NUM_REGS];
    logic [4:0]  rd_addr;
    logic [15:0] rd_data;
    logic [15:0] wdata;
    logic        commit;
`ifdef MIIM_PHY_MODEL_INTR_EN
    logic [15:0] int_en, int_stat;
`endif

    assign irst    = rst | ~phy_resetn_i;
    assign rise    = mdc_sync[1] & ~mdc_q;
    assign fall    = ~mdc_sync[1] & mdc_q;
    // Address/data complete on the rising edge that carries their last bit.
    assign rd_addr = {sh[3:0], mdio_i};
    assign wdata   = {sh, mdio_i};
    assign commit  = rise && (state == S_WDATA) && (cnt == 5'd15);

    always_ff @(posedge clk) begin
        if (irst) begin
            mdc_sync <= 2'b00;
            mdc_q    <= 1'b0;
        end else begin
            mdc_sync <= {mdc_sync[0], mdc_i};
            mdc_q    <= mdc_sync[1];
        end
    end

    // Register read mux, evaluated on the final REGAD bit to load the shadow.
    always_comb begin
        rd_data = 16'h0000;
        if (int'(rd_addr) < NUM_REGS) begin
            case (rd_addr)
                5'd1:    rd_data = 16'h796D;
                5'd2:    rd_data = PHY_ID1;
                5'd3:    rd_data = PHY_ID2;
                default: rd_data = regs[rd_addr];
            endcase
`ifdef MIIM_PHY_MODEL_INTR_EN
            if (rd_addr == 5'd18) rd_data = int_en;
            if (rd_addr == 5'd19) rd_data = int_stat;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (irst) state <= S_PRE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_PRE:   if (rise && !mdio_i && pre_cnt == 6'd32) state_nxt = S_ST;
            S_ST:    if (rise) state_nxt = mdio_i ? S_OP : S_PRE;
            // Only 10 (read) and 01 (write) are legal opcodes.
            S_OP:    if (rise && cnt == 5'd1) state_nxt = (sh[0] != mdio_i) ? S_PHYAD : S_PRE;
            S_PHYAD: if (rise && cnt == 5'd4) state_nxt = S_REGAD;
            S_REGAD: if (rise && cnt == 5'd4)
                         state_nxt = (phyad_r != PHY_ADDR) ? S_SKIP : (op_rd ? S_TA_RD : S_TA_WR);
            // TA + 16 data bits of a frame for another PHY.
            S_SKIP:  if (rise && cnt == 5'd17) state_nxt = S_PRE;
            // cnt counts rises here; the fall right after REGAD is ignored.
            S_TA_RD: if (fall && cnt == 5'd1) state_nxt = S_RDATA;
            S_TA_WR: if (rise && cnt == 5'd1) state_nxt = S_WDATA;
            S_RDATA: if (fall && cnt == 5'd16) state_nxt = S_PRE;
            S_WDATA: if (commit) state_nxt = S_PRE;
            default: state_nxt = S_PRE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (irst) begin
            pre_cnt <= 6'd0;
            cnt     <= 5'd0;
            sh      <= 15'd0;
            op_rd   <= 1'b0;
            phyad_r <= 5'd0;
            regad_r <= 5'd0;
            shadow  <= 16'h0000;
            mdio_o  <= 1'b0;
            mdio_oe <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 16'h0000;
            regs[0] <= 16'h1140;
`ifdef MIIM_PHY_MODEL_INTR_EN
            int_en   <= 16'h0000;
            int_stat <= 16'h0000;
`endif
        end else begin
            // Per-state bit counter: RDATA paces on falling edges, the rest on rising.
            if (state_nxt != state)                        cnt <= 5'd0;
            else if (state != S_PRE &&
                     ((state == S_RDATA) ? fall : rise))   cnt <= cnt + 5'd1;

            // Leaving PRE always clears the preamble count for the next frame.
            if (state != S_PRE)  pre_cnt <= 6'd0;
            else if (rise)       pre_cnt <= !mdio_i ? 6'd0 :
                                            (pre_cnt == 6'd32) ? 6'd32 : pre_cnt + 6'd1;

            if (rise) sh <= {sh[13:0], mdio_i};

            if (rise && state == S_OP && cnt == 5'd1)    op_rd   <= sh[0];
            if (rise && state == S_PHYAD && cnt == 5'd4) phyad_r <= rd_addr;
            if (rise && state == S_REGAD && cnt == 5'd4) begin
                regad_r <= rd_addr;
                shadow  <= rd_data;
            end

            if (fall && state == S_TA_RD && cnt == 5'd1) begin
                mdio_oe <= 1'b1;
                mdio_o  <= 1'b0;
            end

            if (fall && state == S_RDATA) begin
                if (cnt == 5'd16) begin
                    mdio_oe <= 1'b0;
                    mdio_o  <= 1'b0;
`ifdef MIIM_PHY_MODEL_INTR_EN
                    if (regad_r == 5'd19) int_stat <= 16'h0000;
`endif
                end else begin
                    mdio_o <= shadow[15];
                    shadow <= {shadow[14:0], 1'b0};
                end
            end

            if (commit) begin
                if (regad_r == 5'd0) begin
                    if (wdata[15]) begin
                        // Soft reset: bit 15 self-clears, writable regs return to 0.
                        for (int i = 0; i < NUM_REGS; i++) regs[i] <= 16'h0000;
                        regs[0] <= 16'h1140;
`ifdef MIIM_PHY_MODEL_INTR_EN
                        int_en   <= 16'h0000;
                        int_stat <= 16'h0000;
`endif
                    end else begin
                        regs[0] <= {1'b0, wdata[14:0]};
`ifdef MIIM_PHY_MODEL_INTR_EN
                        if ({wdata[13], wdata[6]} != {regs[0][13], regs[0][6]})
                            int_stat[14] <= 1'b1;
`endif
                    end
                end else if (regad_r > 5'd3 && int'(regad_r) < NUM_REGS) begin
`ifdef MIIM_PHY_MODEL_INTR_EN
                    if (regad_r == 5'd18)      int_en <= wdata;
                    else if (regad_r != 5'd19) regs[regad_r] <= wdata;
`else
                    regs[regad_r] <= wdata;
`endif
                end
            end
        end
    end

    // Speed select from {reg0[6], reg0[13]}; both set resolves to 1G.
    always_ff @(posedge clk) begin
        if (irst) speed_o <= 3'b100;
        else begin
            case ({regs[0][6], regs[0][13]})
                2'b01:   speed_o <= 3'b010;
                2'b00:   speed_o <= 3'b001;
                default: speed_o <= 3'b100;
            endcase
        end
    end

`ifdef MIIM_PHY_MODEL_INTR_EN
    always_ff @(posedge clk) begin
        if (irst) phy_intn_o <= 1'b1;
        else      phy_intn_o <= ~|(int_en & int_stat);
    end
`else
    assign phy_intn_o = 1'b1;
`endif

endmodule

// File: tb/tb_miim_phy_model.sv
// Bench for miim_phy_model: an MDIO master drives clause-22 frames; expected
// read data is queued when a read is issued and compared when it returns.
module tb_miim_phy_model;
    localparam logic [4:0] PA   = 5'd3;
    localparam int         HALF = 50;

    logic       clk = 1'b0;
    logic       rst, mdc, mdio_drv, mdio_den, phy_resetn;
    logic       mdio_o, mdio_oe, phy_intn;
    logic [2:0] speed;
    logic       mdio_line;

    int vectors = 0, miscompares = 0;
    int oe_cnt = 0;
    logic [15:0] exp_q [$];

    // Open-drain style line with pull-up.
    assign mdio_line = mdio_oe ? mdio_o : (mdio_den ? mdio_drv : 1'b1);

    miim_phy_model #(.PHY_ADDR(PA), .NUM_REGS(24)) dut (
        .clk(clk), .rst(rst), .mdc_i(mdc), .mdio_i(mdio_line),
        .mdio_o(mdio_o), .mdio_oe(mdio_oe), .phy_resetn_i(phy_resetn),
        .phy_intn_o(phy_intn), .speed_o(speed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) oe_cnt <= oe_cnt + int'(mdio_oe);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mbit(input logic b);
        mdio_den = 1'b1;
        mdio_drv = b;
        #HALF mdc = 1'b1;
        #HALF mdc = 1'b0;
    endtask

    // Released bit: master samples the line at the MDC rising edge.
    task automatic rbit(output logic s, output logic oe);
        mdio_den = 1'b0;
        #HALF mdc = 1'b1;
        s  = mdio_line;
        oe = mdio_oe;
        #HALF mdc = 1'b0;
    endtask

    task automatic header(input int pre, input bit rd, input logic [4:0] pa, input logic [4:0] ra);
        repeat (pre) mbit(1'b1);
        mbit(1'b0); mbit(1'b1);
        mbit(rd); mbit(!rd);
        for (int i = 4; i >= 0; i--) mbit(pa[i]);
        for (int i = 4; i >= 0; i--) mbit(ra[i]);
    endtask

    task automatic rd_frame(input string tag, input logic [4:0] pa, input logic [4:0] ra,
                            input int pre, input bit resp);
        logic s, oe, all_oe;
        logic [15:0] d;
        int oe0;
        oe0 = oe_cnt;
        header(pre, 1'b1, pa, ra);
        rbit(s, oe);
        if (resp) chk({tag, "/ta1_oe"}, oe, 0);
        rbit(s, oe);
        if (resp) begin
            chk({tag, "/ta2_oe"}, oe, 1);
            chk({tag, "/ta2_val"}, s, 0);
        end
        all_oe = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            rbit(s, oe);
            d[i]   = s;
            all_oe = all_oe & oe;
        end
        #HALF;
        if (resp) begin
            chk({tag, "/data_oe"}, all_oe, 1);
            if (exp_q.size() == 0) chk({tag, "/sb_empty"}, 1, 0);
            else                   chk({tag, "/rdata"}, d, exp_q.pop_front());
            chk({tag, "/oe_rel"}, mdio_oe, 0);
        end else begin
            chk({tag, "/no_drive"}, oe_cnt - oe0, 0);
        end
    endtask

    // abort_bit >= 0: assert rst while that data bit (15..0) is on the wire.
    task automatic wr_frame(input logic [4:0] ra, input logic [15:0] wd, input int abort_bit);
        header(32, 1'b0, PA, ra);
        mbit(1'b1); mbit(1'b0);
        for (int i = 15; i >= 0; i--) begin
            if (i == abort_bit) begin
                mdio_drv = wd[i];
                #(HALF/2) rst = 1'b1;
                #(HALF/2) mdc = 1'b1;
                #HALF     mdc = 1'b0;
                #20       rst = 1'b0;
                mdio_den = 1'b0;
                #30;
                chk("abort/oe", mdio_oe, 0);
                return;
            end
            mbit(wd[i]);
        end
        mdio_den = 1'b0;
        #HALF;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; phy_resetn = 1'b1; mdc = 1'b0; mdio_den = 1'b0; mdio_drv = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        chk("rst/oe", mdio_oe, 0);
        chk("rst/o", mdio_o, 0);
        chk("rst/intn", phy_intn, 1);
        chk("rst/speed", speed, 3'b100);
        rst = 1'b0;
        #100;

        exp_q.push_back(16'h796D);
        rd_frame("rd_reg1", PA, 5'd1, 32, 1'b1);

        wr_frame(5'd0, 16'h0100, -1);
        #20 chk("speed_10m", speed, 3'b001);
        exp_q.push_back(16'h0100);
        rd_frame("rd_reg0", PA, 5'd0, 32, 1'b1);

        rd_frame("bad_phyad", PA + 5'd1, 5'd2, 32, 1'b0);
        exp_q.push_back(16'h0141);
        rd_frame("rd_id1", PA, 5'd2, 32, 1'b1);
        exp_q.push_back(16'h0CC2);
        rd_frame("rd_id2", PA, 5'd3, 32, 1'b1);

        rd_frame("short_pre", PA, 5'd1, 31, 1'b0);
        exp_q.push_back(16'h796D);
        rd_frame("after_short", PA, 5'd1, 32, 1'b1);

        wr_frame(5'd4, 16'hA5A5, 8);
        exp_q.push_back(16'h0000);
        rd_frame("rd_reg4_abort", PA, 5'd4, 32, 1'b1);
        chk("abort/speed", speed, 3'b100);

        wr_frame(5'd5, 16'h1234, -1);
        exp_q.push_back(16'h1234);
        rd_frame("rd_reg5", PA, 5'd5, 32, 1'b1);
        wr_frame(5'd1, 16'hFFFF, -1);
        exp_q.push_back(16'h796D);
        rd_frame("rd_reg1_ro", PA, 5'd1, 32, 1'b1);
        wr_frame(5'd30, 16'hBEEF, -1);
        exp_q.push_back(16'h0000);
        rd_frame("rd_oob", PA, 5'd30, 32, 1'b1);

        wr_frame(5'd0, 16'h8000, -1);
        exp_q.push_back(16'h1140);
        rd_frame("rd_softrst", PA, 5'd0, 32, 1'b1);
        exp_q.push_back(16'h0000);
        rd_frame("rd_reg5_clr", PA, 5'd5, 32, 1'b1);

        wr_frame(5'd18, 16'h4000, -1);
        wr_frame(5'd0, 16'h2100, -1);
        #100;
        chk("speed_100m", speed, 3'b010);
`ifdef MIIM_PHY_MODEL_INTR_EN
        chk("intn_set", phy_intn, 0);
        exp_q.push_back(16'h4000);
        rd_frame("rd_reg19", PA, 5'd19, 32, 1'b1);
        #100;
        chk("intn_clr", phy_intn, 1);
`else
        chk("intn_tied", phy_intn, 1);
        exp_q.push_back(16'h4000);
        rd_frame("rd_reg18", PA, 5'd18, 32, 1'b1);
`endif

        @(posedge clk); #2 phy_resetn = 1'b0;
        repeat (3) @(posedge clk);
        #2 phy_resetn = 1'b1;
        #20 chk("hwrst/speed", speed, 3'b100);
        exp_q.push_back(16'h1140);
        rd_frame("rd_hwrst", PA, 5'd0, 32, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/miim_phy_model.md
Name: miim_phy_model

Overview:
- Cycle-accurate behavioural MDIO/MII management slave for simulation benches of the GigE MAC and its MIIM master.
- Decodes IEEE 802.3 clause-22 frames on MDC/MDIO against a parametrised PHY address.
- Holds a small register file with standard control/status/ID semantics and drives read data back on MDIO.
- Derives the speed and interrupt outputs from register contents, replacing a fixed-tie-off skeleton.

Parameters:
- PHY_ADDR, 5'd0, PHY address this model responds to.
- NUM_REGS, 32, number of implemented registers (1..32); addresses at or above NUM_REGS read 16'h0000 and ignore writes.
- PHY_ID1, 16'h0141, value of read-only register 2.
- PHY_ID2, 16'h0CC2, value of read-only register 3.

Ports:
- clk, input, 1, bench sampling clock, at least 8x the MDC frequency.
- rst, input, 1, synchronous active-high reset.
- mdc_i, input, 1, management clock from the MAC, asynchronous to clk.
- mdio_i, input, 1, MDIO line as seen by the PHY.
- mdio_o, output, 1, PHY drive value.
- mdio_oe, output, 1, PHY output enable; the bench builds the tristate pad.
- phy_resetn_i, input, 1, active-low PHY hardware reset, sampled on clk; same effect as rst.
- phy_intn_o, output, 1, active-low interrupt.
- speed_o, output, 3, one-hot speed: 100 = 1G, 010 = 100M, 001 = 10M.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. Internal reset = rst | ~phy_resetn_i.
- Reset values: mdio_o = 0, mdio_oe = 0, phy_intn_o = 1, speed_o = 3'b100, state = PRE, reg0 = 16'h1140, writable registers = 0.
- MDC handling: mdc_i passes through a 2-flop synchronizer.
  - A rising edge is detected on the clk where sync[1] = 1 and the previous value = 0.
  - mdio_i is sampled on that same clk.
  - Outputs change only on the clk following a detected falling edge.
- PRE: 6-bit preamble counter, saturating at 32.
  - Each sampled 1 increments the counter; a sampled 0 with count < 32 clears it.
  - A 0 with count = 32 moves to ST.
- ST: a sampled 1 moves to OP; a 0 returns to PRE with the counter cleared.
- OP: 2 bits. 10 = read, 01 = write; 00 or 11 returns to PRE.
- PHYAD: 5 bits, MSB first. REGAD: 5 bits, MSB first.
  - If PHYAD != PHY_ADDR, enter SKIP. SKIP counts 18 rising edges with mdio_oe held at 0, then goes to PRE.
- TA, read: the first bit is undriven. After the falling edge following the first TA bit, drive mdio_oe = 1, mdio_o = 0.
- TA, write: sample 2 bits and ignore their values.
- RDATA: shadow register loaded at the end of REGAD. 16 bits, MSB first; each bit is placed on mdio_o after an MDC falling edge.
  - mdio_oe is released after the falling edge following bit 0.
  - Then go to PRE with the counter cleared.
- WDATA: shift in 16 bits. On the 16th rising edge, commit to the register and go to PRE.
- Register semantics:
  - reg0 is R/W. Bit 15 written as 1 loads reg0 = 16'h1140, clears all writable registers, and reads back 0.
  - reg1 reads 16'h796D; writes ignored.
  - reg2 = PHY_ID1, reg3 = PHY_ID2; writes ignored.
  - All others below NUM_REGS are R/W.
- speed_o from {reg0[6], reg0[13]}: 10 -> 100, 01 -> 010, 00 -> 001, 11 -> 100. Registered, updated one clk after the write commit.
- Reset mid-frame: state = PRE, counter = 0, mdio_oe = 0 on the same clk. No partial write is committed.
- Simultaneous MDC edge and reset: reset wins.

Optional Feature:
- Macro: MIIM_PHY_MODEL_INTR_EN.
- With the macro defined:
  - reg18 = interrupt enable (R/W); reg19 = interrupt status.
  - A write to reg0 that changes bits 13 or 6 sets reg19[14] (speed changed).
  - phy_intn_o = ~|(reg18 & reg19), registered.
  - A read of reg19 returns its value and clears it after RDATA completes.
  - Writes to reg19 are ignored.
- Without the macro: reg18 and reg19 are plain R/W, and phy_intn_o is constant 1.

Test Plan:
- Reset, then read reg1 at PHY_ADDR with a 32-bit preamble -> data 16'h796D; mdio_oe low during the first TA bit and high for the second TA bit plus 16 data bits.
- Write 16'h0100 to reg0 -> speed_o = 3'b001 one clk after commit; read reg0 returns 16'h0100.
- Frame with PHYAD = PHY_ADDR + 1 -> mdio_oe stays 0 for the whole frame; the next valid read of reg2 returns PHY_ID1.
- 31-bit preamble then ST -> frame ignored, no drive; an immediately following full preamble plus read succeeds.
- Assert rst during the 8th WDATA bit of a write to reg4 -> reg4 still 0, mdio_oe 0; the next read of reg4 returns 16'h0000.
- With MIIM_PHY_MODEL_INTR_EN: write reg18 = 16'h4000, then write reg0 = 16'h2100 -> phy_intn_o = 0; read reg19 returns 16'h4000 and phy_intn_o returns to 1 after the frame.
